// File: rtl/dcache_assoc_ctrl_pkg.sv
// Shared types and helpers for the set-associative write-back D-cache controller.
package dcache_assoc_ctrl_pkg;

    // INIT sweep valid/dirty | IDLE accept | LOOKUP tag compare | EVICT victim wb | REFILL read | WAIT refill data
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        EVICT,
        REFILL,
        WAIT
    } dcache_state_e;

    localparam int unsigned META_TAG_W = 32;

    typedef struct packed {
        logic [META_TAG_W-1:0] tag;
        logic                  dirty;
        logic                  valid;
    } dcache_meta_t;

    function automatic logic [31:0] merge_word(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  st);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_assoc_ctrl_if.sv
// Core-side request/response and memory-side block port of the D-cache controller.
interface dcache_assoc_ctrl_if #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BLOCK_BYTES = 128
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_addr;
    logic [31:0]              req_wdata;
    logic [3:0]               req_wstrb;
    logic                     rsp_valid;
    logic [31:0]              rsp_rdata;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_we;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [8*BLOCK_BYTES-1:0] mem_req_wdata;
    logic                     mem_rsp_valid;
    logic [8*BLOCK_BYTES-1:0] mem_rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
               mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/dcache_assoc_ctrl_victim_sel.sv
// Victim way choice: lowest invalid way, otherwise the round-robin pointer.
module dcache_assoc_ctrl_victim_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic [WAY_W-1:0] victim,
    output logic [WAY_W-1:0] rr_next
);
    logic found;

    always_comb begin
        victim  = rr_ptr;
        rr_next = '0;
        found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (WAYS == 1) begin
            victim = '0;
        end else if (rr_ptr != WAY_W'(WAYS - 1)) begin
            rr_next = rr_ptr + WAY_W'(1);
        end
    end
endmodule

// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative, write-back, write-allocate L1 D-cache controller with one
// outstanding miss, dirty-victim eviction and a one-set-per-cycle invalidate sweep.
module dcache_assoc_ctrl
    import dcache_assoc_ctrl_pkg::*;
#(
    parameter int unsigned CACHE_BYTES = 32768,
    parameter int unsigned BLOCK_BYTES = 128,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input logic          clk,
    input logic          rst,
    dcache_assoc_ctrl_if.slave bus
);
    localparam int unsigned SETS   = CACHE_BYTES / (BLOCK_BYTES * WAYS);
    localparam int unsigned OFF_W  = $clog2(BLOCK_BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WORD_W = (OFF_W > 2) ? OFF_W - 2 : 1;
    localparam int unsigned BLK_W  = 8 * BLOCK_BYTES;

    dcache_state_e                 state;
    logic [IDX_W-1:0]              sweep_idx;
    dcache_meta_t [WAYS-1:0]       meta_q [SETS];
    logic [BLK_W-1:0]              data_q [SETS][WAYS];
    logic [SETS-1:0][WAY_W-1:0]    rr_ptr;

    logic [ADDR_W-1:2]             addr_q;
    logic                          we_q;
    logic [31:0]                   wdata_q;
    logic [3:0]                    wstrb_q;
    logic [WAY_W-1:0]              victim_q;

    logic                          req_ready_q;
    logic                          rsp_valid_q;
    logic [31:0]                   rsp_rdata_q;
    logic                          mem_req_valid_q;
    logic                          mem_req_we_q;
    logic [ADDR_W-1:0]             mem_req_addr_q;
    logic [BLK_W-1:0]              mem_req_wdata_q;

    logic [IDX_W-1:0]              idx;
    logic [TAG_W-1:0]              tag;
    logic [WORD_W-1:0]             word_sel;
    logic                          hit;
    logic [WAY_W-1:0]              hit_way;
    logic [WAYS-1:0]               set_valid;
    logic [WAY_W-1:0]              victim_way;
    logic [WAY_W-1:0]              rr_next;
    dcache_meta_t                  victim_meta;
    logic                          unused_addr_lsb;

    assign idx = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign tag = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    if (OFF_W > 2) begin : g_word_sel
        assign word_sel = addr_q[OFF_W-1:2];
    end else begin : g_word_sel_single
        assign word_sel = '0;
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_we    = mem_req_we_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_req_wdata = mem_req_wdata_q;

    function automatic logic [BLK_W-1:0] merge_block(input logic [BLK_W-1:0]  blk,
                                                     input logic [WORD_W-1:0] sel,
                                                     input logic [31:0]       wd,
                                                     input logic [3:0]        st);
        logic [BLK_W-1:0] r;
        r = blk;
        r[sel*32 +: 32] = merge_word(blk[sel*32 +: 32], wd, st);
        return r;
    endfunction

    function automatic dcache_meta_t [WAYS-1:0] clear_vd(input dcache_meta_t [WAYS-1:0] m);
        dcache_meta_t [WAYS-1:0] r;
        r = m;
        for (int w = 0; w < WAYS; w++) begin
            r[w].valid = 1'b0;
            r[w].dirty = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        set_valid = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = meta_q[idx][w].valid;
            if (meta_q[idx][w].valid && meta_q[idx][w].tag == META_TAG_W'(tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    dcache_assoc_ctrl_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim_sel (
        .valid   (set_valid),
        .rr_ptr  (rr_ptr[idx]),
        .victim  (victim_way),
        .rr_next (rr_next)
    );

    assign victim_meta = meta_q[idx][victim_way];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= INIT;
            sweep_idx       <= '0;
            rr_ptr          <= '0;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            victim_q        <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            case (state)
                INIT: begin
                    meta_q[sweep_idx] <= clear_vd(meta_q[sweep_idx]);
                    sweep_idx         <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == IDX_W'(SETS - 1)) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        addr_q      <= bus.req_addr[ADDR_W-1:2];
                        we_q        <= bus.req_we;
                        wdata_q     <= bus.req_wdata;
                        wstrb_q     <= bus.req_wstrb;
                        req_ready_q <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (we_q) begin
                            data_q[idx][hit_way] <= merge_block(data_q[idx][hit_way], word_sel,
                                                                wdata_q, wstrb_q);
                            meta_q[idx][hit_way].dirty <= 1'b1;
                        end else begin
                            rsp_rdata_q <= data_q[idx][hit_way][word_sel*32 +: 32];
                        end
                        rsp_valid_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        victim_q        <= victim_way;
                        rr_ptr[idx]     <= rr_next;
                        mem_req_valid_q <= 1'b1;
                        if (victim_meta.valid && victim_meta.dirty) begin
                            mem_req_we_q    <= 1'b1;
                            mem_req_addr_q  <= {victim_meta.tag[TAG_W-1:0], idx, {OFF_W{1'b0}}};
                            mem_req_wdata_q <= data_q[idx][victim_way];
                            state           <= EVICT;
                        end else begin
                            mem_req_we_q    <= 1'b0;
                            mem_req_addr_q  <= {tag, idx, {OFF_W{1'b0}}};
                            mem_req_wdata_q <= '0;
                            state           <= REFILL;
                        end
                    end
                end
                EVICT: begin
                    if (bus.mem_req_ready) begin
                        mem_req_we_q    <= 1'b0;
                        mem_req_addr_q  <= {tag, idx, {OFF_W{1'b0}}};
                        mem_req_wdata_q <= '0;
                        state           <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_req_addr_q  <= '0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        data_q[idx][victim_q] <= we_q
                            ? merge_block(bus.mem_rsp_data, word_sel, wdata_q, wstrb_q)
                            : bus.mem_rsp_data;
                        meta_q[idx][victim_q] <= '{tag: META_TAG_W'(tag), dirty: we_q, valid: 1'b1};
                        rsp_rdata_q <= we_q ? 32'h0 : bus.mem_rsp_data[word_sel*32 +: 32];
                        rsp_valid_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Directed bench for dcache_assoc_ctrl: init sweep, cold miss, hits, store merge,
// dirty eviction with back-pressure, and reset abandoning an in-flight miss.
module tb_dcache_assoc_ctrl;
    localparam int unsigned BLOCK_BYTES = 128;
    localparam int unsigned BLK_W       = 8 * BLOCK_BYTES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dcache_assoc_ctrl_if #(.ADDR_W(32), .BLOCK_BYTES(BLOCK_BYTES)) bus ();

    dcache_assoc_ctrl #(
        .CACHE_BYTES (32768),
        .BLOCK_BYTES (BLOCK_BYTES),
        .WAYS        (2),
        .ADDR_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] mk_block(input logic [31:0] base);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLOCK_BYTES / 4; i++) b[i*32 +: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] rdata, output bit saw_mem);
        lat     = 1;
        saw_mem = bus.mem_req_valid;
        while (!bus.rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            saw_mem |= bus.mem_req_valid;
        end
        rdata = bus.rsp_rdata;
    endtask

    task automatic hit_access(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              input logic [31:0] exp_rdata);
        int          lat;
        logic [31:0] rdata;
        bit          saw_mem;
        issue(we, addr, wdata, strb);
        wait_rsp(lat, rdata, saw_mem);
        chk({name, "_latency"}, 64'(lat), 64'd2);
        chk({name, "_rdata"}, 64'(rdata), 64'(exp_rdata));
        chk({name, "_no_mem_req"}, 64'(saw_mem), 64'd0);
    endtask

    task automatic mem_accept(input string name, input logic exp_we, input logic [31:0] exp_addr,
                              output logic [BLK_W-1:0] wdata_seen);
        int n;
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 64'(bus.mem_req_valid), 64'd1);
        chk({name, "_we"}, 64'(bus.mem_req_we), 64'(exp_we));
        chk({name, "_addr"}, 64'(bus.mem_req_addr), 64'(exp_addr));
        wdata_seen = bus.mem_req_wdata;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic mem_respond(input string name, input logic [BLK_W-1:0] blk,
                               input logic [31:0] exp_rdata);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = blk;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        chk({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
        chk({name, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BLK_W-1:0] blk_a, blk_b, blk_c, seen, ev0;
        logic [31:0]      ev_addr0;
        bit               stable, saw_rsp;
        int               n;

        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_wstrb     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        blk_a = mk_block(32'hA000_0000);
        blk_a[1*32 +: 32] = 32'hDEAD_BEEF;
        blk_b = mk_block(32'hB000_0000);
        blk_c = mk_block(32'hC000_0000);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
        rst = 1'b0;

        n = 0;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("init_sweep_cycles", 64'(n), 64'd128);

        issue(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        chk("cold_lookup_no_rsp", 64'(bus.rsp_valid), 64'd0);
        mem_accept("cold_refill", 1'b0, 32'h0000_1000, seen);
        mem_respond("cold", blk_a, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("cold_rsp_single_pulse", 64'(bus.rsp_valid), 64'd0);

        hit_access("reload_hit", 1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hDEAD_BEEF);
        hit_access("store_hit", 1'b1, 32'h0000_1004, 32'h0000_00AA, 4'b0001, 32'h0);
        hit_access("load_merged", 1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hDEAD_BEAA);
        hit_access("load_1000", 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hA000_0000);

        issue(1'b0, 32'h0000_5000, 32'h0, 4'h0);
        mem_accept("way1_refill", 1'b0, 32'h0000_5000, seen);
        mem_respond("way1", blk_b, 32'hB000_0000);

        issue(1'b0, 32'h0000_9000, 32'h0, 4'h0);
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ev_addr0 = bus.mem_req_addr;
        ev0      = bus.mem_req_wdata;
        stable   = bus.mem_req_valid;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stable &= bus.mem_req_valid && bus.mem_req_we && !bus.req_ready &&
                      (bus.mem_req_addr == ev_addr0) && (bus.mem_req_wdata == ev0);
        end
        chk("evict_held_stable", 64'(stable), 64'd1);
        mem_accept("evict", 1'b1, 32'h0000_1000, seen);
        chk("evict_word1", 64'(seen[1*32 +: 32]), 64'h0000_0000_DEAD_BEAA);
        chk("evict_word0", 64'(seen[0*32 +: 32]), 64'h0000_0000_A000_0000);
        mem_accept("evict_refill", 1'b0, 32'h0000_9000, seen);

        rst               = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = blk_c;
        @(negedge clk);
        rst = 1'b0;
        n       = 0;
        saw_rsp = 1'b0;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
            bus.mem_rsp_valid = 1'b0;
            saw_rsp |= bus.rsp_valid;
        end
        chk("reinit_sweep_cycles", 64'(n), 64'd128);
        chk("reinit_ignores_mem_rsp", 64'(saw_rsp), 64'd0);

        issue(1'b0, 32'h0000_9000, 32'h0, 4'h0);
        chk("post_rst_lookup_no_rsp", 64'(bus.rsp_valid), 64'd0);
        mem_accept("post_rst_refill", 1'b0, 32'h0000_9000, seen);
        mem_respond("post_rst", blk_c, 32'hC000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
